adder_accumulator: RTL and testbench

- Sequential front/back end for the combinational 4-bit ripple adder (`adder4bit`, A/B/Cin -> S/Co).
- Accepts a stream of operands over a valid/ready handshake and drives the adder's A, B and Cin.
- Captures S/Co each accepted beat and accumulates COUNT operands into a running sum with a sticky overflow flag.
- Presents the final result on a valid/ready output handshake to the downstream consumer.

---
 rtl/adder_accumulator_if.sv | 65 ++++++
 rtl/adder_accumulator.sv | 140 ++++++++++++++
 tb/tb_adder_accumulator.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_accumulator_if.sv
// ----------------------------------------------------------------------------
// adder_accumulator_if
//
// Bundles every non-clock signal of the adder accumulator:
//   - operand stream    : in_valid / in_ready / in_data
//   - adder connection  : add_a / add_b / add_cin out, add_s / add_co back
//   - result stream     : out_valid / out_ready / out_sum / out_ovf
//
// Modports
//   slave  : the accumulator block (accepts operands, drives the adder,
//            offers results).
//   master : the environment around it (operand source, the adder itself
//            and the result consumer).
// ----------------------------------------------------------------------------
interface adder_accumulator_if #(
    parameter int WIDTH = 4
);
    // Operand stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    // Combinational ripple adder hookup
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_co;

    // Result stream
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output add_a,
        output add_b,
        output add_cin,
        input  add_s,
        input  add_co,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_ovf
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  add_a,
        input  add_b,
        input  add_cin,
        output add_s,
        output add_co,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_ovf
    );
endinterface : adder_accumulator_if

// File: rtl/adder_accumulator.sv
// ----------------------------------------------------------------------------
// adder_accumulator
//
// Sequential wrapper around an external combinational WIDTH-bit ripple adder.
// Operands arrive on a valid/ready stream; each accepted operand is added to
// the running accumulator by the external adder (A = acc, B = in_data,
// Cin = 0) and the adder's S/Co are captured on the accepting edge. After
// COUNT operands the sum (modulo 2^WIDTH) and a sticky overflow flag are
// offered on a valid/ready result stream.
//
// Parameters
//   WIDTH : operand / sum width, must match the adder width.
//   COUNT : operands per result, legal range 1..15.
//
// Ports
//   clk  : rising-edge clock.
//   rst  : asynchronous, active-high reset; discards any partial group.
//   bus  : adder_accumulator_if.slave
//            in_valid/in_ready/in_data       operand stream in
//            add_a/add_b/add_cin             to the adder
//            add_s/add_co                    from the adder
//            out_valid/out_ready             result handshake
//            out_sum/out_ovf                 result, zero while out_valid=0
// ----------------------------------------------------------------------------
module adder_accumulator #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    adder_accumulator_if.slave bus
);

    // cnt must be able to hold COUNT itself: it reaches COUNT on the final
    // accepting edge and is only cleared on the result handoff.
    localparam int            CW   = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CW-1:0]    cnt;

    // Registered handshake / result outputs.
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_ovf_q;

    logic             accept;
    logic             ovf_next;

    // in_ready_q is low exactly in DONE, so no operand is taken while a
    // result is pending, including the handoff cycle itself.
    assign accept   = bus.in_valid && in_ready_q;
    assign ovf_next = ovf | bus.add_co;

    // Adder drive: acc + in_data with no carry in. add_b is a direct
    // pass-through so the adder sees the operand in the same cycle it is
    // offered, and add_s is valid by the accepting edge.
    assign bus.add_a   = acc;
    assign bus.add_b   = bus.in_data;
    assign bus.add_cin = 1'b0;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;

    // Single-process FSM: state, datapath registers and the registered
    // outputs all move together so out_* can never disagree with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout so every register
            // samples pre-edge values regardless of statement order.
            state       <= IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= bus.add_s;
                        ovf <= ovf_next;
                        cnt <= cnt + CW'(1);
                        // With COUNT=1, LAST is 0 and the first beat out of
                        // IDLE already completes the group.
                        if (cnt == LAST) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_sum_q   <= bus.add_s;
                            out_ovf_q   <= ovf_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end

                DONE: begin
                    // Result held stable until the consumer takes it; the
                    // datapath is cleared on the same edge as the handoff.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        acc         <= '0;
                        ovf         <= 1'b0;
                        cnt         <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_sum_q   <= '0;
                        out_ovf_q   <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    acc         <= '0;
                    ovf         <= 1'b0;
                    cnt         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_sum_q   <= '0;
                    out_ovf_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule : adder_accumulator

// File: tb/tb_adder_accumulator.sv
// ----------------------------------------------------------------------------
// tb_adder_accumulator
//
// Two instances: u_dut (COUNT=4) and u_dut1 (COUNT=1). Each has its own
// behavioural 4-bit adder closing the loop on add_a/add_b/add_cin.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, i.e. half a cycle after the rising edge that updated them.
// ----------------------------------------------------------------------------
module tb_adder_accumulator;

    localparam int WIDTH = 4;
    localparam int COUNT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adder_accumulator_if #(.WIDTH(WIDTH)) if0 ();
    adder_accumulator_if #(.WIDTH(WIDTH)) if1 ();

    // Behavioural stand-in for adder4bit.
    assign {if0.add_co, if0.add_s} = 5'(if0.add_a) + 5'(if0.add_b) + 5'(if0.add_cin);
    assign {if1.add_co, if1.add_s} = 5'(if1.add_a) + 5'(if1.add_b) + 5'(if1.add_cin);

    adder_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    adder_accumulator #(.WIDTH(WIDTH), .COUNT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One directed group: ops[0] is sent first.
    typedef struct {
        logic [3:0][3:0] ops;
        logic [3:0]      sum;
        logic            ovf;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] a, b, c, d,
                                input logic [3:0] s, input logic o);
        vec_t v;
        v.ops[0] = a;
        v.ops[1] = b;
        v.ops[2] = c;
        v.ops[3] = d;
        v.sum    = s;
        v.ovf    = o;
        return v;
    endfunction

    task automatic drive_beat(input logic [3:0] d);
        if0.in_valid = 1'b1;
        if0.in_data  = d;
        check("in_ready_before_beat", if0.in_ready, 1);
        check("add_b_passthru", if0.add_b, d);
        check("add_cin_zero", if0.add_cin, 0);
        tick();
        if0.in_valid = 1'b0;
    endtask

    // Streams four back-to-back operands with out_ready=1 and checks the
    // one-cycle result pulse and the return to IDLE.
    task automatic run_group(input vec_t v, input string tag);
        int run;
        run = 0;
        if0.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check({tag, "_add_a"}, if0.add_a, run);
            drive_beat(v.ops[k]);
            run = (run + int'(v.ops[k])) % 16;
            if (k < 3) check({tag, "_valid_early"}, if0.out_valid, 0);
        end
        check({tag, "_out_valid"}, if0.out_valid, 1);
        check({tag, "_out_sum"}, if0.out_sum, v.sum);
        check({tag, "_out_ovf"}, if0.out_ovf, v.ovf);
        check({tag, "_in_ready_done"}, if0.in_ready, 0);
        tick();
        check({tag, "_valid_drop"}, if0.out_valid, 0);
        check({tag, "_sum_zero"}, if0.out_sum, 0);
        check({tag, "_ovf_zero"}, if0.out_ovf, 0);
        check({tag, "_in_ready_idle"}, if0.in_ready, 1);
        check({tag, "_acc_clear"}, if0.add_a, 0);
    endtask

    // Reference: sum modulo 16 and whether any running step carried out.
    function automatic void group_ref(input int ops[$], output int s, output bit o);
        s = 0;
        o = 1'b0;
        foreach (ops[i]) begin
            if (s + ops[i] > 15) o = 1'b1;
            s = (s + ops[i]) % 16;
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic       g_valid[8];
        logic [3:0] g_data[8];
        int         run;
        int         grp[$];
        bit         m_done;
        int         m_sum;
        bit         m_ovf;
        int         results;

        if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_in_ready", if0.in_ready, 1);
        check("rst_out_sum", if0.out_sum, 0);
        check("rst_out_ovf", if0.out_ovf, 0);
        check("rst_add_a", if0.add_a, 0);
        check("rst1_in_ready", if1.in_ready, 1);
        check("rst1_out_valid", if1.out_valid, 0);
        rst = 1'b0;
        tick();

        // ---------------- table-driven groups
        vecs[0] = mk(4'd1,  4'd1,  4'd2, 4'd3,  4'd7,  1'b0);
        vecs[1] = mk(4'd15, 4'd15, 4'd1, 4'd0,  4'd15, 1'b1);
        vecs[2] = mk(4'd15, 4'd1,  4'd0, 4'd0,  4'd0,  1'b1);
        vecs[3] = mk(4'd0,  4'd0,  4'd0, 4'd0,  4'd0,  1'b0);
        vecs[4] = mk(4'd5,  4'd5,  4'd5, 4'd5,  4'd4,  1'b1);
        vecs[5] = mk(4'd15, 4'd15, 4'd15, 4'd15, 4'd12, 1'b1);
        for (int i = 0; i < 6; i++) run_group(vecs[i], $sformatf("vec%0d", i));

        // ---------------- backpressure: 8,1,0,0 held for 5 cycles
        if0.out_ready = 1'b0;
        drive_beat(4'd8); drive_beat(4'd1); drive_beat(4'd0); drive_beat(4'd0);
        if0.in_valid = 1'b1;
        if0.in_data  = 4'd5;
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", if0.out_valid, 1);
            check("bp_out_sum", if0.out_sum, 9);
            check("bp_out_ovf", if0.out_ovf, 0);
            check("bp_in_ready", if0.in_ready, 0);
            check("bp_acc_hold", if0.add_a, 9);
            tick();
        end
        // Handoff with in_valid still high: operand must not be taken.
        if0.out_ready = 1'b1;
        tick();
        check("bp_valid_drop", if0.out_valid, 0);
        check("bp_acc_clear", if0.add_a, 0);
        check("bp_in_ready", if0.in_ready, 1);
        tick();   // the held 5 is accepted now
        check("bp_next_first", if0.add_a, 5);
        if0.in_valid = 1'b0;
        drive_beat(4'd0); drive_beat(4'd0); drive_beat(4'd0);
        check("bp_next_valid", if0.out_valid, 1);
        check("bp_next_sum", if0.out_sum, 5);
        tick();

        // ---------------- gapped input: 2, idle x3, 2, idle, 2, 2
        g_valid = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        g_data  = '{4'd2, 4'd7, 4'd7, 4'd7, 4'd2, 4'd7, 4'd2, 4'd2};
        run = 0;
        for (int c = 0; c < 8; c++) begin
            if0.in_valid = g_valid[c];
            if0.in_data  = g_data[c];
            check("gap_add_a", if0.add_a, run);
            check("gap_add_cin", if0.add_cin, 0);
            check("gap_valid_low", if0.out_valid, 0);
            tick();
            if (g_valid[c]) run = (run + int'(g_data[c])) % 16;
        end
        if0.in_valid = 1'b0;
        check("gap_out_valid", if0.out_valid, 1);
        check("gap_out_sum", if0.out_sum, 8);
        check("gap_out_ovf", if0.out_ovf, 0);
        tick();
        check("gap_done_idle", if0.out_valid, 0);

        // ---------------- asynchronous reset mid-group
        drive_beat(4'd7); drive_beat(4'd7);
        check("ar_acc_partial", if0.add_a, 14);
        #2 rst = 1'b1;
        #1;
        check("ar_acc_now", if0.add_a, 0);
        check("ar_out_valid_now", if0.out_valid, 0);
        check("ar_in_ready_now", if0.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_group(mk(4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 1'b0), "after_rst");

        // ---------------- COUNT=1 instance: 9 then 6, in_valid held high
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 4'd9;
        check("c1_in_ready", if1.in_ready, 1);
        tick();
        check("c1_valid_a", if1.out_valid, 1);
        check("c1_sum_a", if1.out_sum, 9);
        check("c1_ovf_a", if1.out_ovf, 0);
        check("c1_busy_a", if1.in_ready, 0);
        if1.in_data = 4'd6;
        tick();
        check("c1_gap_valid", if1.out_valid, 0);
        check("c1_gap_sum", if1.out_sum, 0);
        check("c1_gap_ready", if1.in_ready, 1);
        check("c1_gap_acc", if1.add_a, 0);
        tick();
        check("c1_valid_b", if1.out_valid, 1);
        check("c1_sum_b", if1.out_sum, 6);
        check("c1_ovf_b", if1.out_ovf, 0);
        if1.in_valid = 1'b0;
        tick();
        check("c1_end_valid", if1.out_valid, 0);

        // ---------------- randomized traffic against the protocol model
        m_done  = 1'b0;
        m_sum   = 0;
        m_ovf   = 1'b0;
        results = 0;
        for (int c = 0; c < 1500; c++) begin
            int  s_now;
            bit  o_now;
            logic       v;
            logic [3:0] d;
            logic       r;
            group_ref(grp, s_now, o_now);
            check("rnd_in_ready", if0.in_ready, !m_done);
            check("rnd_out_valid", if0.out_valid, m_done);
            check("rnd_out_sum", if0.out_sum, m_done ? m_sum : 0);
            check("rnd_out_ovf", if0.out_ovf, m_done ? m_ovf : 0);
            check("rnd_add_a", if0.add_a, s_now);
            v = ($urandom_range(0, 9) < 7);
            d = 4'($urandom_range(0, 15));
            r = 1'($urandom_range(0, 1));
            if0.in_valid  = v;
            if0.in_data   = d;
            if0.out_ready = r;
            check("rnd_add_b", if0.add_b, d);
            if (!m_done && v) begin
                grp.push_back(int'(d));
                if (grp.size() == COUNT) begin
                    group_ref(grp, m_sum, m_ovf);
                    m_done = 1'b1;
                    results++;
                end
            end else if (m_done && r) begin
                m_done = 1'b0;
                grp.delete();
            end
            tick();
        end
        check("rnd_results_seen", (results > 50), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_adder_accumulator
